// File: rtl/dmi_arbiter.sv
// Two-master round-robin arbiter in front of the Debug Module DMI port.
// Latency: forwarded op reaches DM one cycle after accept; local op answered one cycle after accept.
// Backpressure: one transaction in flight; non-granted master held off with req_ready low until IDLE.
module dmi_arbiter #(
  parameter int DMI_ADDR_BITS  = 6,
  parameter int DMI_DATA_BITS  = 32,
  parameter int DMI_OP_BITS    = 2,
  parameter int DMI_BITS       = 40,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_valid_i,
  output logic                m0_req_ready_o,
  input  logic [DMI_BITS-1:0] m0_req_data_i,
  output logic                m0_resp_valid_o,
  input  logic                m0_resp_ready_i,
  output logic [DMI_BITS-1:0] m0_resp_data_o,
  input  logic                m1_req_valid_i,
  output logic                m1_req_ready_o,
  input  logic [DMI_BITS-1:0] m1_req_data_i,
  output logic                m1_resp_valid_o,
  input  logic                m1_resp_ready_i,
  output logic [DMI_BITS-1:0] m1_resp_data_o,
  output logic                dm_req_valid_o,
  input  logic                dm_req_ready_i,
  output logic [DMI_BITS-1:0] dm_req_data_o,
  input  logic                dm_resp_valid_i,
  output logic                dm_resp_ready_o,
  input  logic [DMI_BITS-1:0] dm_resp_data_i,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [DMI_OP_BITS-1:0] OP_NOP   = DMI_OP_BITS'(0);
  localparam logic [DMI_OP_BITS-1:0] OP_READ  = DMI_OP_BITS'(1);
  localparam logic [DMI_OP_BITS-1:0] OP_WRITE = DMI_OP_BITS'(2);
  localparam logic [DMI_OP_BITS-1:0] OP_FAIL  = DMI_OP_BITS'(2);

  logic [1:0]          state_q, state_d;
  logic                gnt_q, gnt_d;      // granted master index
  logic                last_q, last_d;    // master served most recently
  logic [DMI_BITS-1:0] req_q, req_d;
  logic [DMI_BITS-1:0] resp_q, resp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic                pick_m1;
  logic                any_req;
  logic [DMI_BITS-1:0] sel_req;
  logic [DMI_OP_BITS-1:0] sel_op;
  logic                in_idle;
  logic                gnt_resp_ready;

  // Round-robin pick: a lone requester wins; on a tie the master not served last wins.
  always_comb begin
    any_req = m0_req_valid_i | m1_req_valid_i;
    pick_m1 = (m0_req_valid_i & m1_req_valid_i) ? ~last_q : m1_req_valid_i;
    sel_req = pick_m1 ? m1_req_data_i : m0_req_data_i;
    sel_op  = sel_req[DMI_OP_BITS-1:0];
    gnt_resp_ready = gnt_q ? m1_resp_ready_i : m0_resp_ready_i;
  end

  // Next-state logic for the single-outstanding transaction FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    req_d     = req_q;
    resp_d    = resp_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d = pick_m1;
          req_d = sel_req;
          if (sel_op == OP_READ || sel_op == OP_WRITE) begin
            state_d = S_ISSUE;
          end else begin
            // NOP echoes op 00; the reserved op is refused with op 10.
            resp_d  = {sel_req[DMI_BITS-1 -: DMI_ADDR_BITS], {DMI_DATA_BITS{1'b0}},
                       (sel_op == OP_NOP) ? OP_NOP : OP_FAIL};
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        if (dm_req_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response takes priority over a timeout in the same cycle.
        if (dm_resp_valid_i) begin
          resp_d  = dm_resp_data_i;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_d    = {req_q[DMI_BITS-1 -: DMI_ADDR_BITS], {DMI_DATA_BITS{1'b0}}, OP_FAIL};
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (gnt_resp_ready) begin
          last_d  = gnt_q;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State registers; reset abandons any in-flight transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      req_q     <= '0;
      resp_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      req_q     <= req_d;
      resp_q    <= resp_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Output decode: valids and data come from state; ready strobes are gated off during reset.
  always_comb begin
    in_idle         = (state_q == S_IDLE) && !rst;
    m0_req_ready_o  = in_idle & m0_req_valid_i & ~pick_m1;
    m1_req_ready_o  = in_idle & m1_req_valid_i & pick_m1;
    m0_resp_valid_o = (state_q == S_RESP) && !gnt_q;
    m1_resp_valid_o = (state_q == S_RESP) && gnt_q;
    m0_resp_data_o  = m0_resp_valid_o ? resp_q : '0;
    m1_resp_data_o  = m1_resp_valid_o ? resp_q : '0;
    dm_req_valid_o  = (state_q == S_ISSUE);
    dm_req_data_o   = dm_req_valid_o ? req_q : '0;
    // IDLE also drains stray responses, e.g. one arriving after a timeout.
    dm_resp_ready_o = !rst && (state_q == S_IDLE || state_q == S_WAIT);
    busy_o          = (state_q != S_IDLE);
    timeout_o       = timeout_q;
  end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Bench for dmi_arbiter: directed scenarios plus randomized transactions.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected responses come from an op-level reference model.
module tb_dmi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req_valid_i, m0_req_ready_o, m0_resp_valid_o, m0_resp_ready_i;
  logic [39:0] m0_req_data_i, m0_resp_data_o;
  logic        m1_req_valid_i, m1_req_ready_o, m1_resp_valid_o, m1_resp_ready_i;
  logic [39:0] m1_req_data_i, m1_resp_data_o;
  logic        dm_req_valid_o, dm_req_ready_i, dm_resp_valid_i, dm_resp_ready_o;
  logic [39:0] dm_req_data_o, dm_resp_data_i;
  logic        busy_o, timeout_o;

  int total = 0;
  int bad   = 0;
  bit exp_to = 1'b0;

  dmi_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o), .m0_req_data_i(m0_req_data_i),
    .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i), .m0_resp_data_o(m0_resp_data_o),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o), .m1_req_data_i(m1_req_data_i),
    .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i), .m1_resp_data_o(m1_resp_data_o),
    .dm_req_valid_o(dm_req_valid_o), .dm_req_ready_i(dm_req_ready_i), .dm_req_data_o(dm_req_data_o),
    .dm_resp_valid_i(dm_resp_valid_i), .dm_resp_ready_o(dm_resp_ready_o), .dm_resp_data_i(dm_resp_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: what the master must receive for a request, given how the DM behaved.
  function automatic logic [39:0] model_resp(input logic [39:0] req, input bit answered, input logic [39:0] dmw);
    logic [5:0] a;
    a = req[39:34];
    case (req[1:0])
      2'b00:   return {a, 32'h0, 2'b00};
      2'b11:   return {a, 32'h0, 2'b10};
      default: return answered ? dmw : {a, 32'h0, 2'b10};
    endcase
  endfunction

  function automatic logic rdy(input int m);
    return (m == 1) ? m1_req_ready_o : m0_req_ready_o;
  endfunction
  function automatic logic rv(input int m);
    return (m == 1) ? m1_resp_valid_o : m0_resp_valid_o;
  endfunction
  function automatic logic [39:0] rd(input int m);
    return (m == 1) ? m1_resp_data_o : m0_resp_data_o;
  endfunction

  task automatic set_req(input int m, input logic v, input logic [39:0] d);
    if (m == 1) begin m1_req_valid_i = v; m1_req_data_i = d; end
    else begin m0_req_valid_i = v; m0_req_data_i = d; end
  endtask

  task automatic set_rr(input int m, input logic v);
    if (m == 1) m1_resp_ready_i = v; else m0_resp_ready_i = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_to = 1'b0;
  endtask

  // One full transaction for master m, starting and ending at a falling edge.
  task automatic run_txn(input int m, input logic [39:0] req, input int rdy_dly, input int rsp_dly,
                         input bit answer, input logic [39:0] dmw, input int exp_wait);
    logic [39:0] exp;
    bit fwd;
    int n;
    fwd = (req[1:0] == 2'b01) || (req[1:0] == 2'b10);
    exp = model_resp(req, answer, dmw);
    set_req(m, 1'b1, req);
    #1;
    total++; if (rdy(m) !== 1'b1) begin bad++; $display("FAIL grant m%0d ready got=%b exp=1", m, rdy(m)); end
    total++; if (rdy(1-m) !== 1'b0) begin bad++; $display("FAIL other_ready m%0d got=%b exp=0", 1-m, rdy(1-m)); end
    @(negedge clk);
    set_req(m, 1'b0, 40'h0);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b exp=1", busy_o); end
    total++; if (rdy(1-m) !== 1'b0) begin bad++; $display("FAIL other_ready_busy got=%b exp=0", rdy(1-m)); end
    if (fwd) begin
      for (int i = 0; i < rdy_dly; i++) begin
        total++; if (dm_req_valid_o !== 1'b1 || dm_req_data_o !== req) begin
          bad++; $display("FAIL dm_req_hold cyc=%0d got=%b/%h exp=1/%h", i, dm_req_valid_o, dm_req_data_o, req); end
        @(negedge clk);
      end
      total++; if (dm_req_valid_o !== 1'b1 || dm_req_data_o !== req) begin
        bad++; $display("FAIL dm_req got=%b/%h exp=1/%h", dm_req_valid_o, dm_req_data_o, req); end
      total++; if (timeout_o !== exp_to) begin bad++; $display("FAIL timeout_in_issue got=%b exp=%b", timeout_o, exp_to); end
      dm_req_ready_i = 1'b1;
      @(negedge clk);
      dm_req_ready_i = 1'b0;
      total++; if (dm_req_valid_o !== 1'b0 || dm_resp_ready_o !== 1'b1) begin
        bad++; $display("FAIL wait_state dm_req_valid=%b dm_resp_ready=%b exp 0/1", dm_req_valid_o, dm_resp_ready_o); end
      if (answer) begin
        repeat (rsp_dly) @(negedge clk);
        dm_resp_valid_i = 1'b1;
        dm_resp_data_i  = dmw;
        @(negedge clk);
        dm_resp_valid_i = 1'b0;
        dm_resp_data_i  = 40'h0;
      end else begin
        n = 0;
        while (rv(m) !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        total++; if (n !== exp_wait) begin bad++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, exp_wait); end
        exp_to = 1'b1;
      end
    end else begin
      total++; if (dm_req_valid_o !== 1'b0) begin bad++; $display("FAIL local_no_dm got=%b exp=0", dm_req_valid_o); end
    end
    total++; if (rv(m) !== 1'b1 || rd(m) !== exp) begin
      bad++; $display("FAIL resp m%0d got=%b/%h exp=1/%h", m, rv(m), rd(m), exp); end
    total++; if (rv(1-m) !== 1'b0 || rd(1-m) !== 40'h0) begin
      bad++; $display("FAIL other_resp got=%b/%h exp=0/0", rv(1-m), rd(1-m)); end
    total++; if (timeout_o !== exp_to) begin bad++; $display("FAIL timeout_flag got=%b exp=%b", timeout_o, exp_to); end
    set_rr(m, 1'b1);
    @(negedge clk);
    set_rr(m, 1'b0);
    total++; if (busy_o !== 1'b0 || rv(m) !== 1'b0) begin
      bad++; $display("FAIL back_to_idle busy=%b resp_valid=%b exp 0/0", busy_o, rv(m)); end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (busy_o !== 1'b0 || timeout_o !== 1'b0 || dm_req_valid_o !== 1'b0 || dm_req_data_o !== 40'h0) begin
      bad++; $display("FAIL reset_state busy=%b to=%b dmv=%b dmd=%h exp 0", busy_o, timeout_o, dm_req_valid_o, dm_req_data_o); end
    total++; if (m0_resp_valid_o !== 1'b0 || m1_resp_valid_o !== 1'b0 || m0_resp_data_o !== 40'h0 || m1_resp_data_o !== 40'h0) begin
      bad++; $display("FAIL reset_resp got=%b%b exp=00", m0_resp_valid_o, m1_resp_valid_o); end
    total++; if (dm_resp_ready_o !== 1'b1) begin bad++; $display("FAIL idle_dm_resp_ready got=%b exp=1", dm_resp_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    do_reset();
    set_req(1, 1'b1, {6'h21, 32'hBBBB0001, 2'b10});
    run_txn(0, {6'h20, 32'hAAAA0001, 2'b10}, 0, 1, 1'b1, {6'h20, 32'h1, 2'b00}, 0);
    run_txn(1, {6'h21, 32'hBBBB0001, 2'b10}, 0, 1, 1'b1, {6'h21, 32'h2, 2'b00}, 0);
    set_req(1, 1'b1, {6'h22, 32'hBBBB0002, 2'b10});
    run_txn(0, {6'h23, 32'hAAAA0002, 2'b10}, 0, 0, 1'b1, {6'h23, 32'h3, 2'b00}, 0);
    run_txn(1, {6'h22, 32'hBBBB0002, 2'b10}, 0, 0, 1'b1, {6'h22, 32'h4, 2'b00}, 0);
  endtask

  task automatic test_read();
    run_txn(0, {6'h11, 32'h0, 2'b01}, 0, 3, 1'b1, {6'h11, 32'hDEADBEEF, 2'b00}, 0);
  endtask

  task automatic test_local();
    run_txn(1, {6'h04, 32'h1234, 2'b00}, 0, 0, 1'b0, 40'h0, 0);
    run_txn(1, {6'h05, 32'h5678, 2'b11}, 0, 0, 1'b0, 40'h0, 0);
  endtask

  task automatic test_stall();
    run_txn(0, {6'h2A, 32'hCAFEF00D, 2'b10}, 10, 2, 1'b1, {6'h2A, 32'h0, 2'b00}, 0);
  endtask

  task automatic test_timeout();
    run_txn(0, {6'h10, 32'h0, 2'b01}, 0, 0, 1'b0, 40'h0, 256);
    dm_resp_valid_i = 1'b1;
    dm_resp_data_i  = {6'h10, 32'h77777777, 2'b00};
    #1;
    total++; if (dm_resp_ready_o !== 1'b1) begin bad++; $display("FAIL stray_drain got=%b exp=1", dm_resp_ready_o); end
    @(negedge clk);
    dm_resp_valid_i = 1'b0;
    dm_resp_data_i  = 40'h0;
    for (int i = 0; i < 3; i++) begin
      total++; if (m0_resp_valid_o !== 1'b0 || m1_resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL stray_dropped cyc=%0d got=%b%b%b exp=000", i, m0_resp_valid_o, m1_resp_valid_o, busy_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_in_wait();
    set_req(0, 1'b1, {6'h12, 32'h0, 2'b01});
    @(negedge clk);
    set_req(0, 1'b0, 40'h0);
    dm_req_ready_i = 1'b1;
    @(negedge clk);
    dm_req_ready_i = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy_o !== 1'b1 || timeout_o !== 1'b1) begin
      bad++; $display("FAIL pre_reset busy=%b to=%b exp=1/1", busy_o, timeout_o); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({busy_o, timeout_o, dm_req_valid_o, dm_resp_ready_o, m0_req_ready_o, m1_req_ready_o,
                 m0_resp_valid_o, m1_resp_valid_o} !== 8'h00 || dm_req_data_o !== 40'h0 || m0_resp_data_o !== 40'h0) begin
      bad++; $display("FAIL reset_mid_wait outputs busy=%b to=%b dmv=%b dmr=%b exp all 0", busy_o, timeout_o, dm_req_valid_o, dm_resp_ready_o); end
    rst = 1'b0;
    exp_to = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy_o !== 1'b0 || m0_resp_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      bad++; $display("FAIL abandoned_txn busy=%b rv=%b to=%b exp 000", busy_o, m0_resp_valid_o, timeout_o); end
  endtask

  task automatic test_coincide();
    run_txn(0, {6'h13, 32'h0, 2'b01}, 0, 255, 1'b1, {6'h13, 32'h600DF00D, 2'b00}, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      int m;
      logic [39:0] req, dmw;
      m   = int'($urandom_range(0, 1));
      req = {6'($urandom), 32'($urandom), 2'($urandom)};
      dmw = {req[39:34], 32'($urandom), 2'($urandom_range(0, 3))};
      run_txn(m, req, int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'b1, dmw, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_req_valid_i = 1'b0; m0_req_data_i = 40'h0; m0_resp_ready_i = 1'b0;
    m1_req_valid_i = 1'b0; m1_req_data_i = 40'h0; m1_resp_ready_i = 1'b0;
    dm_req_ready_i = 1'b0; dm_resp_valid_i = 1'b0; dm_resp_data_i = 40'h0;
    @(negedge clk);
    test_reset();
    test_arbitration();
    test_read();
    test_local();
    test_stall();
    test_timeout();
    test_reset_in_wait();
    test_coincide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
- Shares the single DMI port of the Debug Module between two debug masters:
  - master 0: the JTAG DTM request/response path, after the handshake receiver in the core clock domain;
  - master 1: a second debug master, e.g. a UART debug bridge.
- Round-robin arbitration, one outstanding transaction at a time.
- Request format {addr, data, op}; routes the DM response back to the granted master.
- Answers NOP and reserved ops locally; converts a hung DM access into a "failed" response after a timeout.

Parameters:
- DMI_ADDR_BITS, 6, DMI address field width.
- DMI_DATA_BITS, 32, DMI data field width.
- DMI_OP_BITS, 2, DMI op field width.
- DMI_BITS, 40, request/response word width; must equal ADDR+DATA+OP.
- TIMEOUT_CYCLES, 256, cycles in WAIT_RESP before a forced failed response; must be ≥2.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- m0_req_valid_i  input  1  master 0 request valid
- m0_req_ready_o  output  1  master 0 request accepted
- m0_req_data_i  input  DMI_BITS  {addr, data, op}
- m0_resp_valid_o  output  1  master 0 response valid
- m0_resp_ready_i  input  1  master 0 response taken
- m0_resp_data_o  output  DMI_BITS  {addr, data, op}
- m1_* (six ports)  same directions and widths as m0_*  master 1 equivalents
- dm_req_valid_o  output  1  request to DM valid
- dm_req_ready_i  input  1  DM accepts request
- dm_req_data_o  output  DMI_BITS  forwarded request
- dm_resp_valid_i  input  1  DM response valid
- dm_resp_ready_o  output  1  arbiter accepts DM response
- dm_resp_data_i  input  DMI_BITS  DM response
- busy_o  output  1  high whenever state != IDLE
- timeout_o  output  1  sticky; set on any timeout, cleared only by rst

Behaviour:
- Field layout: op = [1:0], data = [33:2], addr = [39:34].
- Op encoding:
  - 01 read and 10 write: forwarded to the DM.
  - 00 nop: answered locally as {addr, 0, 00}.
  - 11 reserved: answered locally as {addr, 0, 10}.
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; all outputs and timeout_o = 0.
  - Latched request/response = 0; round-robin pointer last=1, so master 0 wins the first tie.
  - Any in-flight transaction is abandoned; no response is issued for it.
- IDLE:
  - Grant selection: if exactly one mX_req_valid_i, grant that master; if both, grant the master != last.
  - mX_req_ready_o is combinationally high for the granted master only, in IDLE only.
  - The request is latched at that edge. Next state: ISSUE for op 01/10, RESP for op 00/11 (local answer latched).
  - dm_resp_ready_o=1 in IDLE; a stray DM response (e.g. one arriving after a timeout) is consumed and discarded.
- ISSUE:
  - dm_req_valid_o=1 and dm_req_data_o = latched request, both held stable until dm_req_ready_i.
  - On dm_req_ready_i: go to WAIT_RESP; timeout counter cleared.
  - No timeout in ISSUE; the valid/ready contract is never broken.
- WAIT_RESP:
  - dm_resp_ready_o=1; counter increments each cycle.
  - On dm_resp_valid_i: latch dm_resp_data_i and go to RESP.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: latch {addr, 0, 10}, set timeout_o, go to RESP.
  - If dm_resp_valid_i and timeout coincide, the real response wins and timeout_o is not set.
- RESP:
  - mX_resp_valid_o=1 for the granted master only; data held stable.
  - On mX_resp_ready_i: last = granted master; go to IDLE.
- Latency, no DM wait states:
  - Forwarded op: request accept → ISSUE at +1 → DM response → RESP at +1 → resp_valid.
  - Local op: resp_valid one cycle after request accept.
- The non-granted master sees ready=0 throughout and its request stays pending.
- dm_req_valid_o and the resp_valid outputs are registered state decodes with no combinational path from inputs. mX_req_ready_o is the exception: combinational from the req_valid inputs in IDLE.

Test Plan:
- Master 0 read {addr=0x11, op=01}, DM ready immediately, DM returns {0x11, 0xDEADBEEF, 00} 3 cycles later → m0_resp_data_o = that value; m1 outputs stay 0; busy_o high from accept through response handshake.
- Both masters present writes in the same cycle after reset → m0 granted first, m1 second; both present again → m0 granted (last=1 after m1), confirming alternation.
- Master 1 nop {addr=0x04, data=0x1234, op=00} → response {0x04, 0, 00} one cycle after accept; dm_req_valid_o never asserted. Op=11 → response op=10.
- DM never responds to m0 read addr=0x10 → after exactly 256 cycles in WAIT_RESP, m0 response {0x10, 0, 10}, timeout_o=1. A late DM response then arrives in IDLE → dropped, no resp_valid on either master.
- dm_req_ready_i held low 10 cycles → dm_req_valid_o and data stable throughout, no timeout. rst asserted during WAIT_RESP → next cycle all outputs 0, state IDLE, timeout_o=0.
- dm_resp_valid_i on exactly the 256th WAIT_RESP cycle → real DM data returned, timeout_o stays 0.
